// File: rtl/phtrack_seq.sv
// Pilot phase-tracking sequencer: estimator start pulse, per-subcarrier pilot/data allocation code,
// estimate tracking. Optional WAIT-state timeout enabled by defining PHTRACK_TIMEOUT_EN.
module phtrack_seq #(
    parameter int unsigned N_SC        = 2048,
    parameter int unsigned PIL_SPACING = 16,
    parameter int unsigned PIL_OFFSET  = 0,
    parameter logic [10:0] LFSR_SEED   = 11'h7FF,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        sym_start,
    input  logic        din_val,
    input  logic        est_oval,
    output logic        est_start,
    output logic [1:0]  alloc_vec,
    output logic [10:0] sc_idx,
    output logic        ph_upd,
    output logic        busy,
    output logic        err_sync,
    output logic        err_timeout
);

    if (N_SC / PIL_SPACING != 128 || PIL_OFFSET >= PIL_SPACING || LFSR_SEED == 11'd0
        || TIMEOUT_CYC == 0) begin : g_bad_cfg
        $error("phtrack_seq: invalid parameter set");
    end

    typedef enum logic [2:0] {StIdle, StStart, StRun, StWait, StDone} state_e;

    localparam logic [10:0] SC_LAST = 11'(N_SC - 1);

    state_e      state_q, state_d;
    logic [10:0] sc_idx_q, sc_idx_d;
    logic [10:0] lfsr_q;
    logic        got_oval_q, got_oval_d;
    logic        is_pilot;
    logic        pil_adv;

    assign is_pilot = (32'(sc_idx_q) % PIL_SPACING) == PIL_OFFSET;
    assign pil_adv  = (state_q == StRun) && din_val && is_pilot;

`ifdef PHTRACK_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_timeout_q, err_timeout_d;

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sc_idx_d   = sc_idx_q;
        got_oval_d = got_oval_q;
        err_sync   = 1'b0;
`ifdef PHTRACK_TIMEOUT_EN
        tmo_cnt_d     = '0;
        err_timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (sym_start) state_d = StStart;
            end
            StStart: begin
                sc_idx_d   = '0;
                got_oval_d = 1'b0;
                state_d    = StRun;
            end
            StRun: begin
                if (est_oval) got_oval_d = 1'b1;
                if (din_val) begin
                    sc_idx_d = sc_idx_q + 11'd1;
                    if (sc_idx_q == SC_LAST) begin
                        state_d = (got_oval_q || est_oval) ? StDone : StWait;
                    end
                end
            end
            StWait: begin
                if (est_oval) begin
                    state_d = StDone;
                end
`ifdef PHTRACK_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = StIdle;
                    err_timeout_d = 1'b1;
                end
                tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
            end
            StDone: begin
                state_d = sym_start ? StStart : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A new symbol start while one is in flight aborts it and restarts.
        if (sym_start && (state_q == StStart || state_q == StRun || state_q == StWait)) begin
            err_sync = 1'b1;
            state_d  = StStart;
`ifdef PHTRACK_TIMEOUT_EN
            err_timeout_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sc_idx_q   <= '0;
            got_oval_q <= 1'b0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            state_q    <= state_d;
            sc_idx_q   <= sc_idx_d;
            got_oval_q <= got_oval_d;
            if (frame_start) begin
                lfsr_q <= LFSR_SEED;
            end else if (pil_adv) begin
                lfsr_q <= {lfsr_q[0] ^ lfsr_q[2], lfsr_q[10:1]};
            end
        end
    end

`ifdef PHTRACK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end
`endif

    assign est_start = (state_q == StStart);
    assign ph_upd    = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sc_idx    = sc_idx_q;
    assign alloc_vec = ((state_q == StRun) && is_pilot) ? (lfsr_q[0] ? 2'b10 : 2'b01) : 2'b00;

endmodule
